ysyx_040066_wb_arbiter: RTL

Arbiter for the single integer register-file write port. It sits between the in-order writeback stage and the regfile, and shares the port among three sources: the pipeline writeback result, the multi-cycle multiplier and the multi-cycle divider. Multiplier and divider results are parked in one-entry holding buffers and drained into idle write-port cycles. A starvation counter stalls the pipeline when a parked result has waited too long.

---
 rtl/ysyx_040066_wb_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ysyx_040066_wb_arbiter.sv
// Purpose: shares the single regfile write port among pipeline writeback, multiplier and divider.
// Latency: pipeline writes pass through combinationally; mul/div results write no earlier than the cycle after acceptance.
// Backpressure: mul/div see ready low while their buffer is occupied; wb_block stalls writeback when a parked result starves.
module ysyx_040066_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_rd,
  input  logic [63:0] pipe_data,
  input  logic        mul_valid,
  output logic        mul_ready,
  input  logic [4:0]  mul_rd,
  input  logic [63:0] mul_data,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic [4:0]  div_rd,
  input  logic [63:0] div_data,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [63:0] rf_data,
  output logic        wb_block,
  output logic        mul_pend,
  output logic        div_pend
);

  localparam logic [2:0] LIM = 3'(STARVE_LIMIT);

  // parked multiplier result
  logic        r_mul_vld;
  logic [4:0]  r_mul_rd;
  logic [63:0] r_mul_dat;
  logic [2:0]  r_mul_cnt;
  // parked divider result
  logic        r_div_vld;
  logic [4:0]  r_div_rd;
  logic [63:0] r_div_dat;
  logic [2:0]  r_div_cnt;
  // set when the divider entry was parked before (or together with) the multiplier entry
  logic        r_div_older;

  logic w_mul_starved;
  logic w_div_starved;
  logic w_pipe_sel;
  logic w_sel_div;
  logic w_sel_mul;
  logic w_mul_fill;
  logic w_div_fill;
  logic w_mul_clr;
  logic w_div_clr;

  assign mul_ready = ~rst & ~r_mul_vld;
  assign div_ready = ~rst & ~r_div_vld;
  assign mul_pend  = r_mul_vld;
  assign div_pend  = r_div_vld;

  assign w_mul_starved = r_mul_vld & (r_mul_cnt >= LIM);
  assign w_div_starved = r_div_vld & (r_div_cnt >= LIM);
  assign wb_block      = ~rst & (w_mul_starved | w_div_starved);

  // Pipeline has priority unless a starved buffer forces it to yield.
  assign w_pipe_sel = ~rst & pipe_wen & (pipe_rd != 5'd0) & ~wb_block;
  assign w_sel_div  = ~rst & ~w_pipe_sel & r_div_vld & (~r_mul_vld | r_div_older);
  assign w_sel_mul  = ~rst & ~w_pipe_sel & r_mul_vld & ~(r_div_vld & r_div_older);

  // Results targeting x0 are swallowed at the handshake and never parked.
  assign w_mul_fill = mul_valid & mul_ready & (mul_rd != 5'd0);
  assign w_div_fill = div_valid & div_ready & (div_rd != 5'd0);

  // A buffer leaves when it wins the port or when the pipeline overwrites its register (newer value wins).
  assign w_mul_clr = w_sel_mul | (w_pipe_sel & r_mul_vld & (r_mul_rd == pipe_rd));
  assign w_div_clr = w_sel_div | (w_pipe_sel & r_div_vld & (r_div_rd == pipe_rd));

  // Write-port mux driven by the selection above.
  always_comb begin
    rf_wen  = 1'b0;
    rf_rd   = 5'd0;
    rf_data = 64'd0;
    if (w_pipe_sel) begin
      rf_wen  = 1'b1;
      rf_rd   = pipe_rd;
      rf_data = pipe_data;
    end else if (w_sel_div) begin
      rf_wen  = 1'b1;
      rf_rd   = r_div_rd;
      rf_data = r_div_dat;
    end else if (w_sel_mul) begin
      rf_wen  = 1'b1;
      rf_rd   = r_mul_rd;
      rf_data = r_mul_dat;
    end
  end

  // Multiplier buffer: fill, drain/squash, and saturating wait count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_vld <= 1'b0;
      r_mul_rd  <= 5'd0;
      r_mul_dat <= 64'd0;
      r_mul_cnt <= 3'd0;
    end else if (w_mul_fill) begin
      r_mul_vld <= 1'b1;
      r_mul_rd  <= mul_rd;
      r_mul_dat <= mul_data;
      r_mul_cnt <= 3'd0;
    end else if (w_mul_clr) begin
      r_mul_vld <= 1'b0;
      r_mul_cnt <= 3'd0;
    end else if (r_mul_vld && (r_mul_cnt != 3'd7)) begin
      r_mul_cnt <= r_mul_cnt + 3'd1;
    end
  end

  // Divider buffer: fill, drain/squash, and saturating wait count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_vld <= 1'b0;
      r_div_rd  <= 5'd0;
      r_div_dat <= 64'd0;
      r_div_cnt <= 3'd0;
    end else if (w_div_fill) begin
      r_div_vld <= 1'b1;
      r_div_rd  <= div_rd;
      r_div_dat <= div_data;
      r_div_cnt <= 3'd0;
    end else if (w_div_clr) begin
      r_div_vld <= 1'b0;
      r_div_cnt <= 3'd0;
    end else if (r_div_vld && (r_div_cnt != 3'd7)) begin
      r_div_cnt <= r_div_cnt + 3'd1;
    end
  end

  // Age order: a new entry is younger than whatever already sits in the other buffer; simultaneous fills favour div.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_older <= 1'b0;
    end else if (w_div_fill && w_mul_fill) begin
      r_div_older <= 1'b1;
    end else if (w_div_fill) begin
      r_div_older <= ~r_mul_vld;
    end else if (w_mul_fill) begin
      r_div_older <= r_div_vld;
    end
  end

endmodule
